// File: rtl/pipe5_memory_stage.sv
// Memory stage of the five-stage RV32I pipeline: data-bus load/store sequencing, load extension, MEM/WB register.
// Optional misaligned-access trap is enabled by defining PIPE5_MEM_MISALIGN_EXC_EN.
module pipe5_memory_stage #(
    parameter int ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    // execute/memory latch
    input  logic              ex_valid,
    input  logic              ex_dren,
    input  logic              ex_dwen,
    input  logic [31:0]       ex_alu_port_out,
    input  logic [31:0]       ex_store_data,
    input  logic [2:0]        ex_funct3,
    input  logic              ex_wen,
    input  logic [4:0]        ex_reg_rd,
    input  logic [1:0]        ex_w_src,
    input  logic [31:0]       ex_pc,
    input  logic [31:0]       ex_pc4,
    input  logic [31:0]       ex_csr_rdata,
    input  logic              ex_csr_instr,
    input  logic              ex_halt_instr,
    input  logic [31:0]       ex_instr,
    input  logic              flush,
    output logic              mem_stall,
    // data bus
    output logic              dbus_dren,
    output logic              dbus_dwen,
    output logic [ADDR_W-1:0] dbus_addr,
    output logic [31:0]       dbus_wdata,
    output logic [3:0]        dbus_byte_en,
    input  logic              dbus_busy,
    input  logic [31:0]       dbus_rdata,
    // memory/writeback register
    output logic              wb_valid,
    output logic [31:0]       wb_reg_file_wdata,
    output logic [1:0]        wb_w_src,
    output logic              wb_wen,
    output logic [4:0]        wb_reg_rd,
    output logic [31:0]       wb_alu_port_out,
    output logic [31:0]       wb_dload_ext,
    output logic [31:0]       wb_pc,
    output logic [31:0]       wb_pc4,
    output logic              wb_csr_instr,
    output logic [31:0]       wb_csr_rdata,
    output logic              wb_halt_instr,
    output logic [31:0]       wb_instr,
    output logic              wb_exception,
    output logic [3:0]        wb_exc_cause
);

    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    state_t              r_state;
    logic                r_is_load;
    logic                r_is_store;
    logic                r_flushed;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [3:0]          r_byte_en;
    logic [2:0]          r_funct3;
    logic [31:0]         r_alu;
    logic                r_wen;
    logic [4:0]          r_reg_rd;
    logic [1:0]          r_w_src;
    logic [31:0]         r_pc;
    logic [31:0]         r_pc4;
    logic [31:0]         r_csr_rdata;
    logic                r_csr_instr;
    logic                r_halt_instr;
    logic [31:0]         r_instr;

    logic                w_is_mem;
    logic                w_half_acc;
    logic                w_word_acc;
    logic                w_trap;
    logic                w_accept;
    logic                w_in_access;
    logic                w_flush_seen;
    logic [31:0]         w_fixed_addr;
    logic [3:0]          w_byte_en;
    logic [31:0]         w_wdata;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [31:0]         w_load_ext;

    assign w_is_mem   = ex_dren | ex_dwen;
    assign w_half_acc = (ex_funct3[1:0] == 2'b01);
    assign w_word_acc = (ex_funct3[1:0] == 2'b10);

`ifdef PIPE5_MEM_MISALIGN_EXC_EN
    logic       r_exception;
    logic [3:0] r_exc_cause;

    assign w_trap = ex_valid & w_is_mem & ~flush &
                    ((w_half_acc & ex_alu_port_out[0]) | (w_word_acc & (|ex_alu_port_out[1:0])));
    assign w_fixed_addr = ex_alu_port_out;
    assign wb_exception = r_exception;
    assign wb_exc_cause = r_exc_cause;
`else
    // Without the trap, misaligned low bits are dropped so the access lands on its natural boundary.
    assign w_trap       = 1'b0;
    assign w_fixed_addr = {ex_alu_port_out[31:2],
                           ex_alu_port_out[1] & ~w_word_acc,
                           ex_alu_port_out[0] & ~w_half_acc & ~w_word_acc};
    assign wb_exception = 1'b0;
    assign wb_exc_cause = 4'd0;
`endif

    assign w_in_access  = (r_state == S_ACCESS);
    assign w_accept     = (r_state == S_IDLE) & ex_valid & w_is_mem & ~w_trap & ~flush;
    assign w_flush_seen = r_flushed | flush;
    assign mem_stall    = w_accept | (w_in_access & dbus_busy);

    // Bus outputs come straight from the captured registers, so an asynchronous reset drops them at once.
    assign dbus_dren    = w_in_access & r_is_load;
    assign dbus_dwen    = w_in_access & r_is_store;
    assign dbus_addr    = w_in_access ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
    assign dbus_wdata   = w_in_access ? r_wdata : '0;
    assign dbus_byte_en = w_in_access ? r_byte_en : 4'b0000;

    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_byte_en = 4'b1111;
        w_wdata   = ex_store_data;
        case (ex_funct3[1:0])
            2'b00: begin
                w_byte_en = 4'b0001 << w_fixed_addr[1:0];
                w_wdata   = {4{ex_store_data[7:0]}};
            end
            2'b01: begin
                w_byte_en = 4'b0011 << {w_fixed_addr[1], 1'b0};
                w_wdata   = {2{ex_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_byte = 8'h00;
        case (r_addr[1:0])
            2'b00: w_byte = dbus_rdata[7:0];
            2'b01: w_byte = dbus_rdata[15:8];
            2'b10: w_byte = dbus_rdata[23:16];
            2'b11: w_byte = dbus_rdata[31:24];
            default: ;
        endcase
        w_half     = r_addr[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
        w_load_ext = 32'h0000_0000;
        case (r_funct3)
            3'b000: w_load_ext = {{24{w_byte[7]}}, w_byte};
            3'b001: w_load_ext = {{16{w_half[15]}}, w_half};
            3'b010: w_load_ext = dbus_rdata;
            3'b100: w_load_ext = {24'h00_0000, w_byte};
            3'b101: w_load_ext = {16'h0000, w_half};
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state           <= S_IDLE;
            r_is_load         <= 1'b0;
            r_is_store        <= 1'b0;
            r_flushed         <= 1'b0;
            r_addr            <= '0;
            r_wdata           <= '0;
            r_byte_en         <= 4'b0000;
            r_funct3          <= 3'b000;
            r_alu             <= '0;
            r_wen             <= 1'b0;
            r_reg_rd          <= '0;
            r_w_src           <= '0;
            r_pc              <= '0;
            r_pc4             <= '0;
            r_csr_rdata       <= '0;
            r_csr_instr       <= 1'b0;
            r_halt_instr      <= 1'b0;
            r_instr           <= '0;
            wb_valid          <= 1'b0;
            wb_reg_file_wdata <= '0;
            wb_w_src          <= '0;
            wb_wen            <= 1'b0;
            wb_reg_rd         <= '0;
            wb_alu_port_out   <= '0;
            wb_dload_ext      <= '0;
            wb_pc             <= '0;
            wb_pc4            <= '0;
            wb_csr_instr      <= 1'b0;
            wb_csr_rdata      <= '0;
            wb_halt_instr     <= 1'b0;
            wb_instr          <= '0;
`ifdef PIPE5_MEM_MISALIGN_EXC_EN
            r_exception       <= 1'b0;
            r_exc_cause       <= 4'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state      <= S_ACCESS;
                        r_is_load    <= ex_dren;
                        r_is_store   <= ex_dwen;
                        r_flushed    <= 1'b0;
                        r_addr       <= w_fixed_addr[ADDR_W-1:0];
                        r_wdata      <= w_wdata;
                        r_byte_en    <= w_byte_en;
                        r_funct3     <= ex_funct3;
                        r_alu        <= ex_alu_port_out;
                        r_wen        <= ex_wen;
                        r_reg_rd     <= ex_reg_rd;
                        r_w_src      <= ex_w_src;
                        r_pc         <= ex_pc;
                        r_pc4        <= ex_pc4;
                        r_csr_rdata  <= ex_csr_rdata;
                        r_csr_instr  <= ex_csr_instr;
                        r_halt_instr <= ex_halt_instr;
                        r_instr      <= ex_instr;
                        wb_valid     <= 1'b0;
                        wb_wen       <= 1'b0;
`ifdef PIPE5_MEM_MISALIGN_EXC_EN
                        r_exception  <= 1'b0;
                        r_exc_cause  <= 4'd0;
`endif
                    end else if (ex_valid && !flush) begin
                        // Non-memory op, or a trapped misaligned access, retires on the next edge.
                        wb_valid          <= 1'b1;
                        wb_wen            <= ex_wen & ~w_trap;
                        wb_reg_file_wdata <= ex_alu_port_out;
                        wb_dload_ext      <= '0;
                        wb_w_src          <= ex_w_src;
                        wb_reg_rd         <= ex_reg_rd;
                        wb_alu_port_out   <= ex_alu_port_out;
                        wb_pc             <= ex_pc;
                        wb_pc4            <= ex_pc4;
                        wb_csr_instr      <= ex_csr_instr;
                        wb_csr_rdata      <= ex_csr_rdata;
                        wb_halt_instr     <= ex_halt_instr;
                        wb_instr          <= ex_instr;
`ifdef PIPE5_MEM_MISALIGN_EXC_EN
                        r_exception       <= w_trap;
                        r_exc_cause       <= w_trap ? (ex_dwen ? 4'd6 : 4'd4) : 4'd0;
`endif
                    end else begin
                        wb_valid <= 1'b0;
                        wb_wen   <= 1'b0;
`ifdef PIPE5_MEM_MISALIGN_EXC_EN
                        r_exception <= 1'b0;
                        r_exc_cause <= 4'd0;
`endif
                    end
                end
                S_ACCESS: begin
                    if (flush) begin
                        r_flushed <= 1'b1;
                    end
                    if (!dbus_busy) begin
                        // The transaction always completes; a flush only suppresses its retirement.
                        r_state           <= S_IDLE;
                        wb_valid          <= ~w_flush_seen;
                        wb_wen            <= r_is_load & r_wen & ~w_flush_seen;
                        wb_reg_file_wdata <= r_is_load ? w_load_ext : r_alu;
                        wb_dload_ext      <= r_is_load ? w_load_ext : 32'h0000_0000;
                        wb_w_src          <= r_w_src;
                        wb_reg_rd         <= r_reg_rd;
                        wb_alu_port_out   <= r_alu;
                        wb_pc             <= r_pc;
                        wb_pc4            <= r_pc4;
                        wb_csr_instr      <= r_csr_instr;
                        wb_csr_rdata      <= r_csr_rdata;
                        wb_halt_instr     <= r_halt_instr;
                        wb_instr          <= r_instr;
                    end else begin
                        wb_valid <= 1'b0;
                        wb_wen   <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe5_memory_stage.sv
// Directed self-checking bench for pipe5_memory_stage; expected values are hand-computed per step.
module tb_pipe5_memory_stage;

    logic        CLK;
    logic        nRST;
    logic        ex_valid, ex_dren, ex_dwen;
    logic [31:0] ex_alu_port_out, ex_store_data;
    logic [2:0]  ex_funct3;
    logic        ex_wen;
    logic [4:0]  ex_reg_rd;
    logic [1:0]  ex_w_src;
    logic [31:0] ex_pc, ex_pc4, ex_csr_rdata, ex_instr;
    logic        ex_csr_instr, ex_halt_instr;
    logic        flush;
    logic        mem_stall;
    logic        dbus_dren, dbus_dwen;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
    logic [3:0]  dbus_byte_en;
    logic        dbus_busy;
    logic        wb_valid, wb_wen, wb_csr_instr, wb_halt_instr, wb_exception;
    logic [31:0] wb_reg_file_wdata, wb_alu_port_out, wb_dload_ext;
    logic [31:0] wb_pc, wb_pc4, wb_csr_rdata, wb_instr;
    logic [1:0]  wb_w_src;
    logic [4:0]  wb_reg_rd;
    logic [3:0]  wb_exc_cause;

    int checks   = 0;
    int failures = 0;
    int stalls;

    pipe5_memory_stage #(.ADDR_W(32)) dut (
        .CLK(CLK), .nRST(nRST),
        .ex_valid(ex_valid), .ex_dren(ex_dren), .ex_dwen(ex_dwen),
        .ex_alu_port_out(ex_alu_port_out), .ex_store_data(ex_store_data),
        .ex_funct3(ex_funct3), .ex_wen(ex_wen), .ex_reg_rd(ex_reg_rd),
        .ex_w_src(ex_w_src), .ex_pc(ex_pc), .ex_pc4(ex_pc4),
        .ex_csr_rdata(ex_csr_rdata), .ex_csr_instr(ex_csr_instr),
        .ex_halt_instr(ex_halt_instr), .ex_instr(ex_instr),
        .flush(flush), .mem_stall(mem_stall),
        .dbus_dren(dbus_dren), .dbus_dwen(dbus_dwen), .dbus_addr(dbus_addr),
        .dbus_wdata(dbus_wdata), .dbus_byte_en(dbus_byte_en),
        .dbus_busy(dbus_busy), .dbus_rdata(dbus_rdata),
        .wb_valid(wb_valid), .wb_reg_file_wdata(wb_reg_file_wdata),
        .wb_w_src(wb_w_src), .wb_wen(wb_wen), .wb_reg_rd(wb_reg_rd),
        .wb_alu_port_out(wb_alu_port_out), .wb_dload_ext(wb_dload_ext),
        .wb_pc(wb_pc), .wb_pc4(wb_pc4), .wb_csr_instr(wb_csr_instr),
        .wb_csr_rdata(wb_csr_rdata), .wb_halt_instr(wb_halt_instr),
        .wb_instr(wb_instr), .wb_exception(wb_exception), .wb_exc_cause(wb_exc_cause)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_ex();
        ex_valid = 1'b0; ex_dren = 1'b0; ex_dwen = 1'b0;
        ex_alu_port_out = '0; ex_store_data = '0; ex_funct3 = 3'b000;
        ex_wen = 1'b0; ex_reg_rd = '0; ex_w_src = '0; ex_pc = '0; ex_pc4 = '0;
        ex_csr_rdata = '0; ex_csr_instr = 1'b0; ex_halt_instr = 1'b0; ex_instr = '0;
    endtask

    task automatic present(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] sdata, input logic [4:0] rdst);
        clear_ex();
        ex_valid = 1'b1; ex_dren = rd; ex_dwen = wr; ex_funct3 = f3;
        ex_alu_port_out = addr; ex_store_data = sdata; ex_wen = 1'b1; ex_reg_rd = rdst;
        ex_pc = 32'h0000_0400; ex_pc4 = 32'h0000_0404;
    endtask

    // Zero-wait load: accept, one ACCESS cycle, retire two edges after acceptance.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp_addr,
                           input logic [3:0] exp_be, input logic [31:0] exp_ext);
        present(1'b1, 1'b0, f3, addr, 32'h0, 5'd9);
        dbus_busy = 1'b0; dbus_rdata = rdata;
        #1 check({tag, "_accept_stall"}, mem_stall, 1);
        tick();
        clear_ex();
        #1;
        check({tag, "_dren"}, dbus_dren, 1);
        check({tag, "_addr"}, dbus_addr, exp_addr);
        check({tag, "_byte_en"}, dbus_byte_en, exp_be);
        check({tag, "_done_stall"}, mem_stall, 0);
        tick();
        check({tag, "_wb_valid"}, wb_valid, 1);
        check({tag, "_dload_ext"}, wb_dload_ext, exp_ext);
        check({tag, "_rf_wdata"}, wb_reg_file_wdata, exp_ext);
        check({tag, "_wb_wen"}, wb_wen, 1);
    endtask

    initial begin
        clear_ex();
        flush = 1'b0; dbus_busy = 1'b0; dbus_rdata = '0;
        nRST = 1'b0;
        #2;
        check("rst_wb_valid", wb_valid, 0);
        check("rst_mem_stall", mem_stall, 0);
        check("rst_dbus_dren", dbus_dren, 0);
        check("rst_dbus_addr", dbus_addr, 0);
        check("rst_rf_wdata", wb_reg_file_wdata, 0);
        check("rst_exception", wb_exception, 0);
        #10 nRST = 1'b1;
        tick();

        // LB at 0x103: byte 3 = 0x80 sign-extends.
        do_load("lb", 3'b000, 32'h0000_0103, 32'h80FF_FF11, 32'h0000_0100, 4'b1000, 32'hFFFF_FF80);
        // LH at 0x302: upper half 0x8001 sign-extends.
        do_load("lh", 3'b001, 32'h0000_0302, 32'h8001_0000, 32'h0000_0300, 4'b1100, 32'hFFFF_8001);
        // LBU at 0x101: byte 1 = 0x9A zero-extends.
        do_load("lbu", 3'b100, 32'h0000_0101, 32'h0000_9A00, 32'h0000_0100, 4'b0010, 32'h0000_009A);

        // SH of 0x1234_ABCD at 0x202 with busy high for three ACCESS cycles.
        dbus_busy = 1'b1;
        present(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 5'd6);
        stalls = 0;
        #1 if (mem_stall) stalls++;
        tick();
        clear_ex();
        for (int i = 0; i < 3; i++) begin
            #1 if (mem_stall) stalls++;
            check("sh_dwen", dbus_dwen, 1);
            check("sh_dren", dbus_dren, 0);
            check("sh_wdata", dbus_wdata, 32'hABCD_ABCD);
            check("sh_byte_en", dbus_byte_en, 4'b1100);
            check("sh_addr", dbus_addr, 32'h0000_0200);
            tick();
        end
        check("sh_wb_bubble", wb_valid, 0);
        dbus_busy = 1'b0;
        #1 if (mem_stall) stalls++;
        tick();
        check("sh_stall_cycles", stalls, 4);
        check("sh_wb_valid", wb_valid, 1);
        check("sh_wb_wen", wb_wen, 0);
        check("sh_rf_wdata", wb_reg_file_wdata, 32'h0000_0202);

        // ADD (ALU=0x55) immediately followed by LHU of 0x0000_F00D.
        present(1'b0, 1'b0, 3'b000, 32'h0000_0055, 32'h0, 5'd3);
        #1 check("add_stall", mem_stall, 0);
        tick();
        check("add_wb_valid", wb_valid, 1);
        check("add_rf_wdata", wb_reg_file_wdata, 32'h0000_0055);
        check("add_reg_rd", wb_reg_rd, 3);
        check("add_wb_wen", wb_wen, 1);
        present(1'b1, 1'b0, 3'b101, 32'h0000_0300, 32'h0, 5'd4);
        dbus_rdata = 32'h0000_F00D;
        #1 check("lhu_stall", mem_stall, 1);
        tick();
        clear_ex();
        check("lhu_wb_bubble", wb_valid, 0);
        tick();
        check("lhu_wb_valid", wb_valid, 1);
        check("lhu_rf_wdata", wb_reg_file_wdata, 32'h0000_F00D);
        check("lhu_reg_rd", wb_reg_rd, 4);

        // Flush in the second ACCESS cycle of an LW: the request is held until busy drops.
        dbus_busy = 1'b1;
        present(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0, 5'd7);
        tick();
        clear_ex();
        #1 check("lwf_dren_c1", dbus_dren, 1);
        tick();
        flush = 1'b1;
        #1 check("lwf_dren_c2", dbus_dren, 1);
        tick();
        flush = 1'b0;
        #1 check("lwf_dren_c3", dbus_dren, 1);
        check("lwf_addr_c3", dbus_addr, 32'h0000_0400);
        tick();
        dbus_busy = 1'b0;
        #1 check("lwf_dren_done", dbus_dren, 1);
        check("lwf_stall_done", mem_stall, 0);
        tick();
        check("lwf_wb_valid", wb_valid, 0);
        check("lwf_wb_wen", wb_wen, 0);
        check("lwf_dren_after", dbus_dren, 0);

        // Flush while idle squashes a non-memory op.
        present(1'b0, 1'b0, 3'b000, 32'h0000_0077, 32'h0, 5'd8);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        clear_ex();
        check("idle_flush_wb_valid", wb_valid, 0);

        // Misaligned LW at 0x1002 and SW at 0x1001.
        dbus_rdata = 32'hCAFE_BABE;
`ifdef PIPE5_MEM_MISALIGN_EXC_EN
        present(1'b1, 1'b0, 3'b010, 32'h0000_1002, 32'h0, 5'd10);
        #1 check("mis_lw_stall", mem_stall, 0);
        tick();
        clear_ex();
        check("mis_lw_dren", dbus_dren, 0);
        check("mis_lw_wb_valid", wb_valid, 1);
        check("mis_lw_exception", wb_exception, 1);
        check("mis_lw_cause", wb_exc_cause, 4);
        check("mis_lw_wen", wb_wen, 0);
        present(1'b0, 1'b1, 3'b010, 32'h0000_1001, 32'h1111_2222, 5'd0);
        tick();
        clear_ex();
        check("mis_sw_dwen", dbus_dwen, 0);
        check("mis_sw_exception", wb_exception, 1);
        check("mis_sw_cause", wb_exc_cause, 6);
        tick();
        check("mis_clear_exception", wb_exception, 0);
`else
        do_load("mis_lw", 3'b010, 32'h0000_1002, 32'hCAFE_BABE, 32'h0000_1000, 4'b1111, 32'hCAFE_BABE);
        check("mis_lw_exception", wb_exception, 0);
        check("mis_lw_cause", wb_exc_cause, 0);
        // LH at 0x105 is forced to 0x104: low half 0x8765 sign-extends.
        do_load("mis_lh", 3'b001, 32'h0000_0105, 32'h1234_8765, 32'h0000_0104, 4'b0011, 32'hFFFF_8765);
`endif

        // Reset pulsed during ACCESS drops everything asynchronously.
        dbus_busy = 1'b1;
        present(1'b0, 1'b1, 3'b010, 32'h0000_0500, 32'hDEAD_BEEF, 5'd0);
        tick();
        clear_ex();
        #1 check("rstacc_dwen_before", dbus_dwen, 1);
        #2 nRST = 1'b0;
        #1;
        check("rstacc_dwen", dbus_dwen, 0);
        check("rstacc_addr", dbus_addr, 0);
        check("rstacc_wdata", dbus_wdata, 0);
        check("rstacc_stall", mem_stall, 0);
        check("rstacc_wb_valid", wb_valid, 0);
        check("rstacc_rf_wdata", wb_reg_file_wdata, 0);
        #2 nRST = 1'b1;
        dbus_busy = 1'b0;
        tick();
        check("rstacc_idle_dwen", dbus_dwen, 0);
        check("rstacc_idle_valid", wb_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
